// File: rtl/apb_gpio_port.sv
// APB3 GPIO port: per-pin direction (CR), output data with atomic SET/CLR/TGL, synchronised input (IDR).
// Defining GPIO_IRQ_EN adds the rising-edge interrupt (IER, ISR W1C, irq); otherwise those addresses are unmapped.
module apb_gpio_port #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 5,
   parameter int SYNC_N = 2
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic [WIDTH-1:0]  gpio_in,
   output logic [WIDTH-1:0]  gpio_out,
   output logic [WIDTH-1:0]  gpio_oe,
   output logic              irq
);
   localparam logic [ADDR_W-1:0] A_CR  = ADDR_W'(5'h00);
   localparam logic [ADDR_W-1:0] A_ODR = ADDR_W'(5'h04);
   localparam logic [ADDR_W-1:0] A_IDR = ADDR_W'(5'h08);
   localparam logic [ADDR_W-1:0] A_SET = ADDR_W'(5'h0C);
   localparam logic [ADDR_W-1:0] A_CLR = ADDR_W'(5'h10);
   localparam logic [ADDR_W-1:0] A_TGL = ADDR_W'(5'h14);

   logic [ADDR_W-1:0] addr;
   logic              access;
   logic              wr;
   logic [WIDTH-1:0]  wd;
   logic [WIDTH-1:0]  cr;
   logic [WIDTH-1:0]  odr;
   logic [WIDTH-1:0]  idr;
   logic [WIDTH-1:0]  sync_q [SYNC_N];
   logic [31:0]       rdata;
   logic              hit;
   logic              unused_ok;

`ifdef GPIO_IRQ_EN
   localparam logic [ADDR_W-1:0] A_IER = ADDR_W'(5'h18);
   localparam logic [ADDR_W-1:0] A_ISR = ADDR_W'(5'h1C);
   logic [WIDTH-1:0] ier;
   logic [WIDTH-1:0] isr;
   logic [WIDTH-1:0] idr_d;
   logic [WIDTH-1:0] w1c;
   logic             irq_q;
`endif

   assign addr      = {PADDR[ADDR_W-1:2], 2'b00};
   assign access    = PSEL & PENABLE & ~PREADY;
   assign wr        = access & PWRITE;
   assign wd        = PWDATA[WIDTH-1:0];
   assign unused_ok = ^{PWDATA, PADDR[1:0]};
   assign gpio_out  = odr;
   assign gpio_oe   = cr;
   assign idr       = sync_q[SYNC_N-1];

   always_comb begin
      rdata = '0;
      hit   = 1'b1;
      case (addr)
         A_CR:                rdata = 32'(cr);
         A_ODR:               rdata = 32'(odr);
         A_IDR:               rdata = 32'(idr);
         A_SET, A_CLR, A_TGL: rdata = '0;
`ifdef GPIO_IRQ_EN
         A_IER:               rdata = 32'(ier);
         A_ISR:               rdata = 32'(isr);
`endif
         default:             hit   = 1'b0;
      endcase
   end

   // PREADY can only rise from an access phase, so each transfer gets exactly one wait state
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         cr      <= '0;
         odr     <= '0;
      end else begin
         PREADY  <= access;
         PSLVERR <= access & ~hit;
         if (access && !PWRITE)
            PRDATA <= rdata;
         if (wr) begin
            case (addr)
               A_CR:    cr  <= wd;
               A_ODR:   odr <= wd;
               A_SET:   odr <= odr | wd;
               A_CLR:   odr <= odr & ~wd;
               A_TGL:   odr <= odr ^ wd;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int k = 0; k < SYNC_N; k++)
            sync_q[k] <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int k = 1; k < SYNC_N; k++)
            sync_q[k] <= sync_q[k-1];
      end
   end

`ifdef GPIO_IRQ_EN
   assign w1c = (wr && addr == A_ISR) ? wd : '0;
   assign irq = irq_q;

   // a rising edge in the same cycle as a W1C keeps its ISR bit
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         ier   <= '0;
         isr   <= '0;
         idr_d <= '0;
         irq_q <= 1'b0;
      end else begin
         idr_d <= idr;
         if (wr && addr == A_IER)
            ier <= wd;
         isr   <= (isr & ~w1c) | (idr & ~idr_d);
         irq_q <= |(isr & ier);
      end
   end
`else
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_apb_gpio_port.sv
// Bench for apb_gpio_port: expected APB results queued on issue, compared against completed transfers.
module tb_apb_gpio_port;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = 6;
   localparam int SYNC_N = 2;
`ifdef GPIO_IRQ_EN
   localparam bit IRQ_ERR = 1'b0;
`else
   localparam bit IRQ_ERR = 1'b1;
`endif

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic [ADDR_W-1:0] PADDR;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [31:0]       PWDATA;
   logic [31:0]       PRDATA;
   logic              PREADY;
   logic              PSLVERR;
   logic [WIDTH-1:0]  gpio_in;
   logic [WIDTH-1:0]  gpio_out;
   logic [WIDTH-1:0]  gpio_oe;
   logic              irq;

   always #5 PCLK = ~PCLK;

   apb_gpio_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SYNC_N(SYNC_N)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wd;
      logic [31:0]       dat;
      logic              err;
   } op_t;
   typedef struct {
      logic [31:0] dat;
      logic        err;
      logic        to;
   } res_t;

   op_t  exp_q[$];
   res_t act_q[$];
   int   checks = 0;
   int   errors = 0;
   logic [WIDTH-1:0] m_odr;

   // Called #1 after an edge; the access executes two edges later and returns #1 after it.
   task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] dat, input logic err);
      op_t  o;
      res_t r;
      o = '{wr, addr, wd, dat, err};
      exp_q.push_back(o);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      r.to = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge PCLK); #1;
         if (PREADY === 1'b1) begin
            r.to = 1'b0;
            break;
         end
      end
      r.dat = PRDATA;
      r.err = PSLVERR;
      act_q.push_back(r);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge PCLK); #1;
      end
   endtask

   task automatic test_reset;
      PRESET = 1'b1;
      #1;
      checks++;
      if ({PREADY, PSLVERR, PRDATA, gpio_oe, gpio_out, irq} !== '0) begin
         errors++;
         $display("FAIL reset_init: rdy=%b err=%b rdata=%h oe=%h out=%h irq=%b, want all 0",
                  PREADY, PSLVERR, PRDATA, gpio_oe, gpio_out, irq);
      end
      cycles(2);
      PRESET = 1'b0;
      issue(1'b1, 6'h00, 32'hF0, 32'h0, 1'b0);
      issue(1'b1, 6'h04, 32'hA5, 32'h0, 1'b0);
      // manual read of CR, reset asserted while PREADY is high
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 6'h00;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      checks++;
      if (PREADY !== 1'b1 || PRDATA !== 32'hF0 || gpio_out !== 8'hA5) begin
         errors++;
         $display("FAIL reset_pre: rdy=%b rdata=%h out=%h, want 1 000000f0 a5", PREADY, PRDATA, gpio_out);
      end
      #2 PRESET = 1'b1;
      #1;
      checks++;
      if ({PREADY, PRDATA, gpio_oe, gpio_out} !== '0) begin
         errors++;
         $display("FAIL reset_mid: rdy=%b rdata=%h oe=%h out=%h, want all 0", PREADY, PRDATA, gpio_oe, gpio_out);
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      m_odr = '0;
      for (int a = 0; a < 8; a++)
         issue(1'b0, ADDR_W'(a * 4), 32'h0, 32'h0, (a >= 6) ? IRQ_ERR : 1'b0);
      while (exp_q.size() > 0) begin
         op_t  e;
         res_t r;
         e = exp_q.pop_front();
         r = act_q.pop_front();
         checks++;
         if (r.to || r.err !== e.err || (!e.wr && r.dat !== e.dat)) begin
            errors++;
            $display("FAIL reset_reg wr=%b @%h: data=%h err=%b timeout=%b, want data=%h err=%b",
                     e.wr, e.addr, r.dat, r.err, r.to, e.dat, e.err);
         end
      end
   endtask

   task automatic test_rw;
      issue(1'b1, 6'h00, 32'h0000_00F0, 32'h0,  1'b0);
      issue(1'b1, 6'h04, 32'h0000_00A5, 32'h0,  1'b0);
      issue(1'b0, 6'h00, 32'h0, 32'h0000_00F0,  1'b0);
      issue(1'b0, 6'h04, 32'h0, 32'h0000_00A5,  1'b0);
      issue(1'b1, 6'h00, 32'hFFFF_FF0F, 32'h0,  1'b0);
      issue(1'b0, 6'h00, 32'h0, 32'h0000_000F,  1'b0);
      issue(1'b1, 6'h00, 32'h0000_00F0, 32'h0,  1'b0);
      issue(1'b0, 6'h01, 32'h0, 32'h0000_00F0,  1'b0);
      cycles(1);
      checks++;
      if (PREADY !== 1'b0 || gpio_oe !== 8'hF0 || gpio_out !== 8'hA5) begin
         errors++;
         $display("FAIL rw_pins: rdy=%b oe=%h out=%h, want 0 f0 a5", PREADY, gpio_oe, gpio_out);
      end
      m_odr = 8'hA5;
      while (exp_q.size() > 0) begin
         op_t  e;
         res_t r;
         e = exp_q.pop_front();
         r = act_q.pop_front();
         checks++;
         if (r.to || r.err !== e.err || (!e.wr && r.dat !== e.dat)) begin
            errors++;
            $display("FAIL rw wr=%b @%h: data=%h err=%b timeout=%b, want data=%h err=%b",
                     e.wr, e.addr, r.dat, r.err, r.to, e.dat, e.err);
         end
      end
   endtask

   task automatic test_set_clr_tgl;
      logic [31:0] v;
      int          op;
      issue(1'b1, 6'h0C, 32'h0A, 32'h0,  1'b0);
      issue(1'b0, 6'h04, 32'h0,  32'hAF, 1'b0);
      issue(1'b1, 6'h10, 32'h81, 32'h0,  1'b0);
      issue(1'b0, 6'h04, 32'h0,  32'h2E, 1'b0);
      issue(1'b1, 6'h14, 32'hFF, 32'h0,  1'b0);
      issue(1'b0, 6'h04, 32'h0,  32'hD1, 1'b0);
      issue(1'b0, 6'h0C, 32'h0,  32'h0,  1'b0);
      issue(1'b0, 6'h10, 32'h0,  32'h0,  1'b0);
      issue(1'b0, 6'h14, 32'h0,  32'h0,  1'b0);
      m_odr = 8'hD1;
      for (int i = 0; i < 6; i++) begin
         op = $urandom_range(0, 2);
         v  = $urandom;
         case (op)
            0:       m_odr = m_odr | v[WIDTH-1:0];
            1:       m_odr = m_odr & ~v[WIDTH-1:0];
            default: m_odr = m_odr ^ v[WIDTH-1:0];
         endcase
         issue(1'b1, ADDR_W'(12 + 4 * op), v, 32'h0, 1'b0);
         issue(1'b0, 6'h04, 32'h0, 32'(m_odr), 1'b0);
      end
      cycles(1);
      checks++;
      if (gpio_out !== m_odr) begin
         errors++;
         $display("FAIL sct_pins: out=%h, want %h", gpio_out, m_odr);
      end
      while (exp_q.size() > 0) begin
         op_t  e;
         res_t r;
         e = exp_q.pop_front();
         r = act_q.pop_front();
         checks++;
         if (r.to || r.err !== e.err || (!e.wr && r.dat !== e.dat)) begin
            errors++;
            $display("FAIL sct wr=%b @%h: data=%h err=%b timeout=%b, want data=%h err=%b",
                     e.wr, e.addr, r.dat, r.err, r.to, e.dat, e.err);
         end
      end
   endtask

   task automatic test_idr;
      // read executing on edge N+SYNC_N still sees the old pins, one edge later the new ones
      gpio_in = 8'h3C;
      cycles(SYNC_N - 2);
      issue(1'b0, 6'h08, 32'h0, 32'h00, 1'b0);
      issue(1'b0, 6'h08, 32'h0, 32'h3C, 1'b0);
      gpio_in = 8'hC3;
      cycles(SYNC_N - 1);
      issue(1'b0, 6'h08, 32'h0, 32'hC3, 1'b0);
      while (exp_q.size() > 0) begin
         op_t  e;
         res_t r;
         e = exp_q.pop_front();
         r = act_q.pop_front();
         checks++;
         if (r.to || r.err !== e.err || (!e.wr && r.dat !== e.dat)) begin
            errors++;
            $display("FAIL idr wr=%b @%h: data=%h err=%b timeout=%b, want data=%h err=%b",
                     e.wr, e.addr, r.dat, r.err, r.to, e.dat, e.err);
         end
      end
   endtask

   task automatic test_unmapped;
      issue(1'b0, 6'h04, 32'h0, 32'(m_odr), 1'b0);
      issue(1'b1, 6'h24, 32'h55, 32'h0,     1'b1);
      issue(1'b0, 6'h24, 32'h0,  32'h0,     1'b1);
      issue(1'b0, 6'h00, 32'h0,  32'hF0,    1'b0);
      issue(1'b0, 6'h04, 32'h0,  32'(m_odr), 1'b0);
      issue(1'b1, 6'h08, 32'hFF, 32'h0,     1'b0);
      issue(1'b0, 6'h08, 32'h0,  32'hC3,    1'b0);
      issue(1'b0, 6'h3C, 32'h0,  32'h0,     1'b1);
`ifndef GPIO_IRQ_EN
      issue(1'b0, 6'h18, 32'h0,  32'h0,     1'b1);
      issue(1'b1, 6'h1C, 32'hFF, 32'h0,     1'b1);
`endif
      checks++;
      if (gpio_out !== m_odr || gpio_oe !== 8'hF0 || (IRQ_ERR && irq !== 1'b0)) begin
         errors++;
         $display("FAIL unmapped_pins: out=%h oe=%h irq=%b, want %h f0 0", gpio_out, gpio_oe, irq, m_odr);
      end
      while (exp_q.size() > 0) begin
         op_t  e;
         res_t r;
         e = exp_q.pop_front();
         r = act_q.pop_front();
         checks++;
         if (r.to || r.err !== e.err || (!e.wr && r.dat !== e.dat)) begin
            errors++;
            $display("FAIL unmapped wr=%b @%h: data=%h err=%b timeout=%b, want data=%h err=%b",
                     e.wr, e.addr, r.dat, r.err, r.to, e.dat, e.err);
         end
      end
   endtask

`ifdef GPIO_IRQ_EN
   task automatic test_irq;
      gpio_in = 8'h00;
      cycles(SYNC_N + 2);
      issue(1'b1, 6'h1C, 32'hFF, 32'h0, 1'b0);
      issue(1'b1, 6'h18, 32'h00, 32'h0, 1'b0);
      issue(1'b0, 6'h1C, 32'h0,  32'h0, 1'b0);
      gpio_in = 8'h01;
      cycles(SYNC_N + 3);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_masked: irq=%b, want 0", irq);
      end
      issue(1'b0, 6'h1C, 32'h0,  32'h01, 1'b0);
      issue(1'b1, 6'h18, 32'h01, 32'h0,  1'b0);
      cycles(2);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set: irq=%b, want 1", irq);
      end
      issue(1'b1, 6'h1C, 32'h01, 32'h0, 1'b0);
      cycles(1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_w1c: irq=%b, want 0", irq);
      end
      issue(1'b0, 6'h1C, 32'h0, 32'h0, 1'b0);
      // time the W1C so it executes on the same edge that latches a new rise
      gpio_in = 8'h00;
      cycles(SYNC_N + 2);
      gpio_in = 8'h01;
      cycles(SYNC_N - 1);
      issue(1'b1, 6'h1C, 32'h01, 32'h0,  1'b0);
      issue(1'b0, 6'h1C, 32'h0,  32'h01, 1'b0);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_coincide: irq=%b, want 1", irq);
      end
      while (exp_q.size() > 0) begin
         op_t  e;
         res_t r;
         e = exp_q.pop_front();
         r = act_q.pop_front();
         checks++;
         if (r.to || r.err !== e.err || (!e.wr && r.dat !== e.dat)) begin
            errors++;
            $display("FAIL irq wr=%b @%h: data=%h err=%b timeout=%b, want data=%h err=%b",
                     e.wr, e.addr, r.dat, r.err, r.to, e.dat, e.err);
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; gpio_in = '0;
      test_reset();
      test_rw();
      test_set_clr_tgl();
      test_idr();
      test_unmapped();
`ifdef GPIO_IRQ_EN
      test_irq();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
